// File: rtl/reg_reader.sv
// rtl/reg_reader.sv - burst reader over a flattened register bank
//
// Purpose:
//   Accepts a read request (start address, length-1), waits WAIT cycles,
//   then streams one register word per cycle. Addresses wrap modulo NREG.
//   The consumer can hold a beat with rd_stall. rd_abort cancels an
//   active burst.
//
// Ports:
//   sys_clk   in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   reg_q     in   NREG*DW flattened register bank, word i at [i*DW +: DW]
//   rd_req    in   read request, sampled only while idle
//   rd_addr   in   AW   start address, sampled with rd_req
//   rd_len    in   AW   beats minus one, sampled with rd_req
//   rd_stall  in   hold the current beat
//   rd_abort  in   cancel the active burst, block acceptance while idle
//   rd_busy   out  burst in progress
//   rd_valid  out  rd_data carries a beat
//   rd_data   out  DW   beat data, zero when rd_valid is low
//   rd_last   out  final beat of the burst
//
// Configuration:
//   READ_SNAPSHOT_EN  when defined, the whole bank is captured at acceptance
//                     and every beat reads that copy. When undefined, each
//                     beat reads live reg_q at the edge that presents it.

module reg_reader #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int WAIT = 1
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic [NREG*DW-1:0] reg_q,
  input  logic               rd_req,
  input  logic [AW-1:0]      rd_addr,
  input  logic [AW-1:0]      rd_len,
  input  logic               rd_stall,
  input  logic               rd_abort,
  output logic               rd_busy,
  output logic               rd_valid,
  output logic [DW-1:0]      rd_data,
  output logic               rd_last
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAITST = 2'd1,
    XFER   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_C = 4'(WAIT);

  state_t          state_q, state_d;
  logic [3:0]      wait_q, wait_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   len_q, len_d;
  logic [AW-1:0]   beat_q, beat_d;
  logic            busy_d, valid_d, last_d;
  logic [DW-1:0]   data_d;
  logic [AW-1:0]   addr_nxt, beat_nxt;

  // live_word: current register contents.
  // src_word: the data beats are taken from (snapshot or live).
  logic [DW-1:0]   live_word [NREG];
  logic [DW-1:0]   src_word  [NREG];

`ifdef READ_SNAPSHOT_EN
  logic [NREG*DW-1:0] snap_q, snap_d;
`endif

  for (genvar i = 0; i < NREG; i++) begin : g_words
    assign live_word[i] = reg_q[i*DW +: DW];
`ifdef READ_SNAPSHOT_EN
    assign src_word[i]  = snap_q[i*DW +: DW];
`else
    assign src_word[i]  = reg_q[i*DW +: DW];
`endif
  end

  // NREG is a power of two equal to 2**AW, so AW-bit addition wraps for free.
  assign addr_nxt = addr_q + 1'b1;
  assign beat_nxt = beat_q + 1'b1;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    busy_d  = rd_busy;
    valid_d = rd_valid;
    last_d  = rd_last;
    data_d  = rd_data;
`ifdef READ_SNAPSHOT_EN
    snap_d  = snap_q;
`endif

    case (state_q)
      IDLE: begin
        if (rd_req && !rd_abort) begin
          addr_d = rd_addr;
          len_d  = rd_len;
          beat_d = '0;
          wait_d = WAIT_C;
          busy_d = 1'b1;
`ifdef READ_SNAPSHOT_EN
          snap_d = reg_q;
`endif
          if (WAIT == 0) begin
            // No wait states: the first beat goes out on the acceptance
            // edge. Live data equals what the snapshot is capturing now.
            state_d = XFER;
            valid_d = 1'b1;
            data_d  = live_word[rd_addr];
            last_d  = (rd_len == '0);
          end else begin
            state_d = WAITST;
          end
        end
      end

      WAITST: begin
        if (rd_abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          data_d  = '0;
        end else if (wait_q <= 4'd1) begin
          state_d = XFER;
          wait_d  = '0;
          valid_d = 1'b1;
          data_d  = src_word[addr_q];
          last_d  = (len_q == '0);
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      XFER: begin
        if (rd_abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          data_d  = '0;
        end else if (!rd_stall) begin
          if (beat_q == len_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
          end else begin
            addr_d  = addr_nxt;
            beat_d  = beat_nxt;
            data_d  = src_word[addr_nxt];
            last_d  = (beat_nxt == len_q);
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      rd_busy  <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
`ifdef READ_SNAPSHOT_EN
      snap_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      rd_busy  <= busy_d;
      rd_valid <= valid_d;
      rd_last  <= last_d;
      rd_data  <= data_d;
`ifdef READ_SNAPSHOT_EN
      snap_q   <= snap_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_reader.sv
// tb/tb_reg_reader.sv - scoreboard bench for reg_reader
module tb_reg_reader;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int WAIT = 1;

  logic               sys_clk = 1'b0;
  logic               rst;
  logic [NREG*DW-1:0] reg_q;
  logic               rd_req;
  logic [AW-1:0]      rd_addr;
  logic [AW-1:0]      rd_len;
  logic               rd_stall;
  logic               rd_abort;
  logic               rd_busy;
  logic               rd_valid;
  logic [DW-1:0]      rd_data;
  logic               rd_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] bank [NREG];
  logic [DW:0]   sb [$];

  reg_reader #(.DW(DW), .NREG(NREG), .AW(AW), .WAIT(WAIT)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .reg_q    (reg_q),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_len   (rd_len),
    .rd_stall (rd_stall),
    .rd_abort (rd_abort),
    .rd_busy  (rd_busy),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] v);
    bank[i] = v;
    reg_q[i*DW +: DW] = v;
  endtask

  task automatic push_burst(input int a, input int l);
    for (int k = 0; k <= l; k++)
      sb.push_back({(k == l) ? 1'b1 : 1'b0, bank[(a + k) % NREG]});
  endtask

  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    while (rd_busy && cyc < 64) begin
      tick;
      cyc++;
    end
    check({tag, "_timeout"}, 32'(cyc < 64), 32'd1);
  endtask

  // Full burst; optionally keep rd_req high for the whole burst, including
  // the final-beat cycle, to show requests are not queued.
  task automatic run_burst(input string tag, input int a, input int l, input bit hold_req);
    int cyc;
    push_burst(a, l);
    rd_req = 1'b1; rd_addr = AW'(a); rd_len = AW'(l);
    tick;
    if (!hold_req) rd_req = 1'b0;
    check({tag, "_busy"}, 32'(rd_busy), 32'd1);
    wait_idle(tag, cyc);
    rd_req = 1'b0;
    check({tag, "_cycles"}, 32'(cyc), 32'(WAIT + l + 1));
    tick;
    check({tag, "_no_requeue"}, 32'(rd_busy), 32'd0);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  // Beat scoreboard: a beat completes when valid and not stalled or aborted.
  always @(negedge sys_clk) begin
    if (!rst && rd_valid && !rd_stall && !rd_abort) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(rd_data), 32'hFFFF_FFFF);
      end else begin
        logic [DW:0] e;
        e = sb.pop_front();
        check("beat_data", 32'(rd_data), 32'(e[DW-1:0]));
        check("beat_last", 32'(rd_last), 32'(e[DW]));
      end
    end
    if (!rd_valid) check("idle_data_zero", 32'(rd_data), 32'd0);
  end

  initial begin
    int cyc, busy_cnt;
    rst = 1'b1; rd_req = 1'b0; rd_addr = '0; rd_len = '0;
    rd_stall = 1'b0; rd_abort = 1'b0; reg_q = '0;
    for (int i = 0; i < NREG; i++) set_word(i, 16'h1000 + 16'(i));
    tick; tick;
    check("rst_busy",  32'(rd_busy),  32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_last",  32'(rd_last),  32'd0);
    check("rst_data",  32'(rd_data),  32'd0);
    rst = 1'b0;
    tick;

    // Basic timing: addr 2, len 2
    push_burst(2, 2);
    rd_req = 1'b1; rd_addr = 3'd2; rd_len = 3'd2;
    tick;  // T+1
    rd_req = 1'b0;
    check("t1_busy",  32'(rd_busy),  32'd1);
    check("t1_valid", 32'(rd_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick;  // T+2..T+4
      check("tk_valid", 32'(rd_valid), 32'd1);
      check("tk_last",  32'(rd_last),  32'(k == 2));
    end
    tick;  // T+5
    check("t5_busy",  32'(rd_busy),  32'd0);
    check("t5_valid", 32'(rd_valid), 32'd0);

    // Wrap and full-length bursts, request held through the final beat
    run_burst("wrap", 6, 3, 1'b0);
    run_burst("full", 1, NREG - 1, 1'b1);
    run_burst("single", 7, 0, 1'b1);

    // Stall on second beat for 3 cycles
    push_burst(0, 3);
    rd_req = 1'b1; rd_addr = 3'd0; rd_len = 3'd3;
    tick;
    rd_req = 1'b0;
    busy_cnt = 0;
    for (int c = 1; c < 40 && rd_busy; c++) begin
      rd_stall = (c >= 3 && c <= 5);
      busy_cnt++;
      if (c >= 3 && c <= 6) begin
        check("stall_valid", 32'(rd_valid), 32'd1);
        check("stall_data",  32'(rd_data),  32'h1001);
        check("stall_last",  32'(rd_last),  32'd0);
      end
      tick;
    end
    rd_stall = 1'b0;
    check("stall_busy_cycles", 32'(busy_cnt), 32'd8);
    check("stall_sb_empty", 32'(sb.size()), 32'd0);
    tick;

    // Abort on second beat, then immediate new request
    push_burst(0, 3);
    rd_req = 1'b1; rd_addr = 3'd0; rd_len = 3'd3;
    tick;          // T+1
    rd_req = 1'b0;
    tick;          // T+2 beat 0
    tick;          // T+3 beat 1
    check("abort_beat1", 32'(rd_data), 32'h1001);
    rd_abort = 1'b1;
    tick;          // T+4
    rd_abort = 1'b0;
    check("abort_busy",  32'(rd_busy),  32'd0);
    check("abort_valid", 32'(rd_valid), 32'd0);
    check("abort_last",  32'(rd_last),  32'd0);
    sb.delete();
    push_burst(5, 0);
    rd_req = 1'b1; rd_addr = 3'd5; rd_len = 3'd0;
    tick;
    rd_req = 1'b0;
    check("post_abort_accept", 32'(rd_busy), 32'd1);
    wait_idle("post_abort", cyc);
    check("post_abort_sb", 32'(sb.size()), 32'd0);
    tick;

    // Register write one cycle after acceptance
`ifdef READ_SNAPSHOT_EN
    sb.push_back({1'b1, 16'h1003});
`else
    sb.push_back({1'b1, 16'hBEEF});
`endif
    rd_req = 1'b1; rd_addr = 3'd3; rd_len = 3'd0;
    tick;
    rd_req = 1'b0;
    set_word(3, 16'hBEEF);
    wait_idle("snap", cyc);
    check("snap_sb", 32'(sb.size()), 32'd0);
    set_word(3, 16'h1003);
    tick;

    // Reset mid-burst while stalled
    push_burst(0, 3);
    rd_req = 1'b1; rd_addr = 3'd0; rd_len = 3'd3;
    tick;          // T+1
    rd_req = 1'b0;
    tick;          // T+2
    tick;          // T+3
    rd_stall = 1'b1;
    tick;          // T+4
    rst = 1'b1;
    tick;          // T+5
    check("mrst_busy",  32'(rd_busy),  32'd0);
    check("mrst_valid", 32'(rd_valid), 32'd0);
    check("mrst_last",  32'(rd_last),  32'd0);
    check("mrst_data",  32'(rd_data),  32'd0);
    rst = 1'b0; rd_stall = 1'b0;
    sb.delete();

    // Request together with abort while idle is refused
    rd_req = 1'b1; rd_abort = 1'b1;
    tick;
    rd_req = 1'b0; rd_abort = 1'b0;
    check("idle_abort_busy", 32'(rd_busy), 32'd0);
    tick;
    check("idle_abort_valid", 32'(rd_valid), 32'd0);

    // Request in the first cycle after reset release
    rst = 1'b1;
    tick;
    rst = 1'b0;
    push_burst(7, 1);
    rd_req = 1'b1; rd_addr = 3'd7; rd_len = 3'd1;
    tick;
    rd_req = 1'b0;
    check("first_cycle_accept", 32'(rd_busy), 32'd1);
    wait_idle("first_cycle", cyc);
    check("first_cycle_sb", 32'(sb.size()), 32'd0);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_reader.md
REG_READER -- requirements
Module: reg_reader

Interface
REQ-001 Parameter DW, default 16, register data width in bits.
REQ-002 Parameter NREG, default 8, number of readable registers; power of two, 2..16.
REQ-003 Parameter AW, default 3, address width; equals log2(NREG).
REQ-004 Parameter WAIT, default 1, wait-state cycles between request acceptance and first beat; range 0..15.
REQ-005 sys_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 reg_q  in  NREG*DW  flattened register bank contents; word i at bits [i*DW+DW-1 : i*DW].
REQ-008 rd_req  in  1  read request; sampled only when rd_busy=0.
REQ-009 rd_addr  in  AW  start address; sampled with rd_req.
REQ-010 rd_len  in  AW  burst length minus one (0 gives 1 beat, NREG-1 gives NREG beats); sampled with rd_req.
REQ-011 rd_stall  in  1  consumer backpressure; holds the current beat.
REQ-012 rd_abort  in  1  cancels an active burst.
REQ-013 rd_busy  out  1  high from acceptance until burst end.
REQ-014 rd_valid  out  1  rd_data holds a beat.
REQ-015 rd_data  out  DW  beat data; 0 when rd_valid=0.
REQ-016 rd_last  out  1  high with the final beat of a burst.

Function
REQ-017 States IDLE, WAITST, XFER; all outputs registered.
REQ-018 IDLE: rd_req=1 and rd_abort=0 at edge T latch rd_addr, rd_len and the wait count, and set rd_busy=1 from T+1; next state WAITST if WAIT>0, else XFER.
REQ-019 WAITST lasts exactly WAIT cycles; first rd_valid=1 at cycle T+1+WAIT.
REQ-020 XFER: a beat completes in any cycle with rd_valid=1 and rd_stall=0; the next beat is presented in the following cycle (one beat per cycle without stall).
REQ-021 While rd_stall=1, rd_valid, rd_data and rd_last stay unchanged.
REQ-022 Beat address increments by one modulo NREG (NREG-1 wraps to 0).
REQ-023 rd_last=1 on beat number rd_len (0-based), otherwise 0.
REQ-024 The cycle after the last beat completes, rd_busy=0, rd_valid=0 and rd_last=0, and the state is IDLE.
REQ-025 rd_req while rd_busy=1 is ignored, including in the final-beat cycle; there is no queuing.
REQ-026 rd_abort=1 while rd_busy=1: in the next cycle the state is IDLE and rd_busy, rd_valid and rd_last are 0; rd_abort overrides stall and beat completion.
REQ-027 rd_abort=1 in IDLE has no effect except that a simultaneous rd_req is not accepted.
REQ-028 rd_valid never rises in WAITST or IDLE.

Reset
REQ-029 rst=1 at an edge forces IDLE; rd_busy, rd_valid, rd_last and rd_data become 0; the wait counter, beat counter, address and snapshot become 0.
REQ-030 rst overrides every other input, including mid-burst and during a stall; no beat is emitted after it.
REQ-031 rd_req sampled in the first cycle with rst=0 is accepted normally.

Configuration
REQ-032 Macro READ_SNAPSHOT_EN.
REQ-033 Defined: the whole of reg_q is captured into an internal snapshot at the acceptance edge, and every beat returns snapshot data; reg_q changes after acceptance are invisible.
REQ-034 Not defined: there is no snapshot storage; each beat's rd_data is reg_q[addr] sampled at the edge that presents the beat, and rd_data is not refreshed during a stall.

Verification
REQ-035 WAIT=1; reg_q words = 0x1000+i; rd_req with addr=2 and len=2 at T -> rd_valid high at T+2..T+4 with data 0x1002, 0x1003, 0x1004; rd_last only at T+4; rd_busy low at T+5.
REQ-036 addr=6, len=3, NREG=8 -> data sequence from words 6, 7, 0, 1 (wrap); rd_last on word 1.
REQ-037 rd_stall high for 3 cycles on the second beat -> that beat is held for 4 cycles with data unchanged; total burst time extends by 3.
REQ-038 rd_abort pulsed during the second beat of a 4-beat burst -> next cycle rd_busy=0 and rd_valid=0; an rd_req in the following cycle is accepted.
REQ-039 With READ_SNAPSHOT_EN defined, word 3 is written to 0xBEEF one cycle after accepting addr=3 -> rd_data is the old value. Without the macro -> rd_data is 0xBEEF.
REQ-040 rst asserted mid-burst while stalled -> all outputs 0 next cycle; rd_req with rd_abort in IDLE -> not accepted.
